// File: rtl/ram_arb_pkg.sv
// Shared types and width helpers for the RAM bus arbiter.
// Pure declarations: no latency and no flow control of its own.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY    = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  // Index width that stays at least one bit wide for degenerate counts.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_bus_arbiter_if.sv
// CPU-side master ports and the single RAM slave port as one bundle.
// The master modport is the arbiter's view; slave is the masters/RAM side.
interface ram_bus_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  import ram_arb_pkg::*;

  logic [NUM_MASTERS-1:0][ADDR_W-1:0] m_address_in;
  logic [NUM_MASTERS-1:0]             m_sel_in;
  logic [NUM_MASTERS-1:0][MASK_W-1:0] m_write_mask_in;
  logic [NUM_MASTERS-1:0][DATA_W-1:0] m_write_value_in;
  logic [NUM_MASTERS-1:0][DATA_W-1:0] m_read_value_out;
  logic [NUM_MASTERS-1:0]             m_ready_out;
  logic [NUM_MASTERS-1:0]             m_timeout_out;

  logic [ADDR_W-1:0] s_address_out;
  logic              s_sel_out;
  logic [MASK_W-1:0] s_write_mask_out;
  logic [DATA_W-1:0] s_write_value_out;
  logic [DATA_W-1:0] s_read_value_in;
  logic              s_ready_in;

  modport master (
    input  m_address_in, m_sel_in, m_write_mask_in, m_write_value_in,
    output m_read_value_out, m_ready_out, m_timeout_out,
    output s_address_out, s_sel_out, s_write_mask_out, s_write_value_out,
    input  s_read_value_in, s_ready_in
  );

  modport slave (
    output m_address_in, m_sel_in, m_write_mask_in, m_write_value_in,
    input  m_read_value_out, m_ready_out, m_timeout_out,
    input  s_address_out, s_sel_out, s_write_mask_out, s_write_value_out,
    output s_read_value_in, s_ready_in
  );

endinterface

// File: rtl/ram_arb_rr_pick.sv
// Combinational round-robin picker: first requester after i_last, wrapping.
// Zero latency; o_vld low when nothing requests.
module ram_arb_rr_pick
  import ram_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic          o_vld,
  output logic [IW-1:0] o_idx
);

  // Scan farthest-first so the nearest requester after i_last is the final write.
  always_comb begin
    o_vld = 1'b0;
    o_idx = '0;
    for (int i = N; i >= 1; i--) begin
      if (i_req[(int'(i_last) + i) % N]) begin
        o_vld = 1'b1;
        o_idx = IW'((int'(i_last) + i) % N);
      end
    end
  end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Round-robin share of one RAM slave between NUM_MASTERS ports, one transaction in flight.
// IDLE->ready in 2 cycles; masters hold sel until ready; one idle sel cycle between grants; watchdog abort.
module ram_bus_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  ram_bus_arbiter_if.master bus
);

  localparam int IW = idx_w(NUM_MASTERS);
  localparam int TW = idx_w(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  arb_state_e             r_state;
  arb_state_e             w_next;
  logic [IW-1:0]          r_grant;
  logic [IW-1:0]          r_rr_last;
  logic [TW-1:0]          r_timer;
  logic [NUM_MASTERS-1:0] w_gnt_oh;
  logic [NUM_MASTERS-1:0] w_others;
  logic [NUM_MASTERS-1:0] w_req;
  logic                   w_pick_vld;
  logic [IW-1:0]          w_pick_idx;
  logic                   w_busy;
  logic                   w_sel_g;
  logic                   w_done;
  logic                   w_withdraw;
  logic                   w_timeout;

  always_comb begin
    w_gnt_oh          = '0;
    w_gnt_oh[r_grant] = 1'b1;
  end

  // On release the master just served yields unless nobody else is waiting.
  assign w_others = bus.m_sel_in & ~w_gnt_oh;
  assign w_req    = (r_state == ARB_RELEASE && |w_others) ? w_others : bus.m_sel_in;

  ram_arb_rr_pick #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_pick (
    .i_req  (w_req),
    .i_last (r_rr_last),
    .o_vld  (w_pick_vld),
    .o_idx  (w_pick_idx)
  );

  assign w_busy     = (r_state == ARB_BUSY);
  assign w_sel_g    = bus.m_sel_in[r_grant];
  assign w_done     = w_busy && bus.s_ready_in;
  assign w_withdraw = w_busy && !bus.s_ready_in && !w_sel_g;
  assign w_timeout  = w_busy && !bus.s_ready_in && w_sel_g && (r_timer == TMO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ARB_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB_IDLE:    if (w_pick_vld) w_next = ARB_BUSY;
      ARB_BUSY:    if (w_done || w_withdraw || w_timeout) w_next = ARB_RELEASE;
      ARB_RELEASE: w_next = w_pick_vld ? ARB_BUSY : ARB_IDLE;
      default:     w_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    bus.s_sel_out         = 1'b0;
    bus.s_address_out     = '0;
    bus.s_write_mask_out  = '0;
    bus.s_write_value_out = '0;
    bus.m_read_value_out  = '0;
    bus.m_ready_out       = '0;
    bus.m_timeout_out     = '0;
    if (w_busy) begin
      bus.s_sel_out                 = w_sel_g;
      bus.s_address_out             = bus.m_address_in[r_grant];
      bus.s_write_mask_out          = w_sel_g ? bus.m_write_mask_in[r_grant] : '0;
      bus.s_write_value_out         = bus.m_write_value_in[r_grant];
      bus.m_read_value_out[r_grant] = w_timeout ? '0 : bus.s_read_value_in;
      bus.m_ready_out[r_grant]      = w_done || w_timeout;
      bus.m_timeout_out[r_grant]    = w_timeout;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant   <= '0;
      r_rr_last <= IW'(NUM_MASTERS - 1);
      r_timer   <= '0;
    end else begin
      if ((r_state == ARB_IDLE || r_state == ARB_RELEASE) && w_pick_vld)
        r_grant <= w_pick_idx;
      if (w_done || w_timeout)
        r_rr_last <= r_grant;
      r_timer <= (w_busy && w_next == ARB_BUSY) ? r_timer + 1'b1 : '0;
    end
  end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed bench for ram_bus_arbiter with a toggling-ready RAM model.
// Inputs are driven 1ns after posedge, outputs sampled on negedge.
module tb_ram_bus_arbiter;
  import ram_arb_pkg::*;

  localparam int NM  = 2;
  localparam int TMO = 8;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ram_bus_arbiter_if #(.NUM_MASTERS(NM)) bus();

  ram_bus_arbiter #(
    .NUM_MASTERS    (NM),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // RAM model: ready toggles while sel is held, clears once sel drops.
  logic [31:0] mem [16];
  logic        ram_rdy  = 1'b0;
  logic [31:0] ram_rd   = 32'h0;
  logic        ram_hang = 1'b0;

  assign bus.s_ready_in      = ram_rdy;
  assign bus.s_read_value_in = ram_rd;

  always @(posedge clk) begin
    if (bus.s_sel_out) begin
      ram_rdy <= ~ram_rdy & ~ram_hang;
      ram_rd  <= mem[bus.s_address_out[5:2]];
      for (int b = 0; b < 4; b++)
        if (bus.s_write_mask_out[b])
          mem[bus.s_address_out[5:2]][8*b +: 8] = bus.s_write_value_out[8*b +: 8];
    end else begin
      ram_rdy <= 1'b0;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic req(input int m, input logic [31:0] a, input logic [3:0] mk, input logic [31:0] wv);
    bus.m_sel_in[m]         = 1'b1;
    bus.m_address_in[m]     = a;
    bus.m_write_mask_in[m]  = mk;
    bus.m_write_value_in[m] = wv;
  endtask

  task automatic drop(input int m);
    bus.m_sel_in[m]         = 1'b0;
    bus.m_write_mask_in[m]  = 4'h0;
  endtask

  logic [31:0] exp_rdy;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[4] = 32'hAABBCCDD;
    mem[5] = 32'h55555555;
    mem[6] = 32'h66666666;
    bus.m_sel_in         = '0;
    bus.m_address_in     = '0;
    bus.m_write_mask_in  = '0;
    bus.m_write_value_in = '0;

    // Reset state
    smp();
    chk("rst sel",     32'(bus.s_sel_out),           32'h0);
    chk("rst ready",   32'(bus.m_ready_out),         32'h0);
    chk("rst timeout", 32'(bus.m_timeout_out),       32'h0);
    chk("rst mask",    32'(bus.s_write_mask_out),    32'h0);
    chk("rst rd0",     bus.m_read_value_out[0],      32'h0);
    nxt(); reset_n = 1'b1;
    nxt();

    // 1: reset mid-BUSY
    req(0, 32'h10, 4'h0, 32'h0);
    smp();
    nxt(); smp();
    chk("t1 sel busy", 32'(bus.s_sel_out), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("t1 sel in reset",   32'(bus.s_sel_out),   32'h0);
    chk("t1 ready in reset", 32'(bus.m_ready_out), 32'h0);
    drop(0);
    nxt(); reset_n = 1'b1;
    smp();
    chk("t1 state idle", 32'(dut.r_state), 32'(ARB_IDLE));
    chk("t1 sel idle",   32'(bus.s_sel_out), 32'h0);

    // 2: single read by m0
    nxt(); req(0, 32'h10, 4'h0, 32'h0);
    smp(); chk("t2 c0 sel", 32'(bus.s_sel_out), 32'h0);
    nxt(); smp();
    chk("t2 c1 sel",   32'(bus.s_sel_out),     32'h1);
    chk("t2 c1 addr",  bus.s_address_out,      32'h10);
    chk("t2 c1 ready", 32'(bus.m_ready_out),   32'h0);
    nxt(); smp();
    chk("t2 c2 ready", 32'(bus.m_ready_out),   32'h1);
    chk("t2 c2 rd0",   bus.m_read_value_out[0], 32'hAABBCCDD);
    chk("t2 c2 rd1",   bus.m_read_value_out[1], 32'h0);
    nxt(); drop(0); smp();
    chk("t2 c3 sel",   32'(bus.s_sel_out),     32'h0);
    chk("t2 c3 ready", 32'(bus.m_ready_out),   32'h0);

    // 3: contention, both held; rr_last = 0 so grants go 1,0,1,0
    nxt(); req(0, 32'h14, 4'h0, 32'h0); req(1, 32'h18, 4'h0, 32'h0);
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) begin
        nxt();
        if (k == 12) begin drop(0); drop(1); end
      end
      smp();
      exp_rdy = (k == 2 || k == 8) ? 32'h2 : (k == 5 || k == 11) ? 32'h1 : 32'h0;
      chk($sformatf("t3 c%0d ready", k), 32'(bus.m_ready_out), exp_rdy);
      if (k == 2) chk("t3 rd1", bus.m_read_value_out[1], 32'h66666666);
      if (k == 5) chk("t3 rd0", bus.m_read_value_out[0], 32'h55555555);
    end

    // 4: masked write by m1, then read back
    nxt(); req(1, 32'h10, 4'b0011, 32'h11223344);
    smp();
    nxt(); smp();
    chk("t4 mask",  32'(bus.s_write_mask_out), 32'h3);
    chk("t4 wdata", bus.s_write_value_out,     32'h11223344);
    chk("t4 addr",  bus.s_address_out,         32'h10);
    nxt(); smp();
    chk("t4 wr ready", 32'(bus.m_ready_out), 32'h2);
    nxt(); drop(1); smp();
    chk("t4 rel mask", 32'(bus.s_write_mask_out), 32'h0);
    nxt(); req(1, 32'h10, 4'h0, 32'h0);
    smp(); nxt(); smp(); nxt(); smp();
    chk("t4 rd ready", 32'(bus.m_ready_out),    32'h2);
    chk("t4 rd1",      bus.m_read_value_out[1], 32'hAABB3344);
    chk("t4 rd0",      bus.m_read_value_out[0], 32'h0);
    nxt(); drop(1); smp();

    // 5: RAM hangs, watchdog aborts at BUSY cycle 8
    nxt(); ram_hang = 1'b1; req(0, 32'h14, 4'h0, 32'h0);
    smp();
    for (int k = 1; k <= 8; k++) begin
      nxt();
      if (k == 2) req(1, 32'h18, 4'h0, 32'h0);
      smp();
      if (k < 8) begin
        chk($sformatf("t5 c%0d ready", k),   32'(bus.m_ready_out),   32'h0);
        chk($sformatf("t5 c%0d timeout", k), 32'(bus.m_timeout_out), 32'h0);
      end else begin
        chk("t5 tmo ready",   32'(bus.m_ready_out),    32'h1);
        chk("t5 tmo timeout", 32'(bus.m_timeout_out),  32'h1);
        chk("t5 tmo rd0",     bus.m_read_value_out[0], 32'h0);
      end
    end
    nxt(); drop(0); ram_hang = 1'b0; smp();
    chk("t5 rel sel",     32'(bus.s_sel_out),     32'h0);
    chk("t5 rel timeout", 32'(bus.m_timeout_out), 32'h0);
    nxt(); smp();
    chk("t5 m1 sel",  32'(bus.s_sel_out), 32'h1);
    chk("t5 m1 addr", bus.s_address_out,  32'h18);
    nxt(); smp();
    chk("t5 m1 ready",   32'(bus.m_ready_out),    32'h2);
    chk("t5 m1 timeout", 32'(bus.m_timeout_out),  32'h0);
    chk("t5 m1 rd1",     bus.m_read_value_out[1], 32'h66666666);
    nxt(); drop(1); smp();

    // 6: m0 withdraws mid-BUSY, pending m1 is served next
    nxt(); ram_hang = 1'b1; req(0, 32'h14, 4'h0, 32'h0);
    smp();
    nxt(); smp();
    chk("t6 c1 sel",   32'(bus.s_sel_out),   32'h1);
    chk("t6 c1 ready", 32'(bus.m_ready_out), 32'h0);
    nxt(); req(1, 32'h18, 4'h0, 32'h0); smp();
    chk("t6 c2 ready", 32'(bus.m_ready_out), 32'h0);
    nxt(); drop(0); ram_hang = 1'b0; smp();
    chk("t6 c3 sel",   32'(bus.s_sel_out),   32'h0);
    chk("t6 c3 ready", 32'(bus.m_ready_out), 32'h0);
    nxt(); smp();
    chk("t6 c4 sel",   32'(bus.s_sel_out),   32'h0);
    chk("t6 c4 ready", 32'(bus.m_ready_out), 32'h0);
    nxt(); smp();
    chk("t6 c5 sel",  32'(bus.s_sel_out), 32'h1);
    chk("t6 c5 addr", bus.s_address_out,  32'h18);
    nxt(); smp();
    chk("t6 c6 ready", 32'(bus.m_ready_out),    32'h2);
    chk("t6 c6 rd1",   bus.m_read_value_out[1], 32'h66666666);
    nxt(); drop(1); smp();
    nxt();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
